spi_slave: RTL and testbench

Bit-bang SPI target (mode 0, MSB first) that sits on the far side of the SPI master's four pins. It oversamples `spi_cs_n`, `spi_clock` and `spi_mosi` with the system clock, assembles received words for a downstream consumer, and serialises words pulled from an upstream source onto `spi_miso`. The transmit side uses the same get/empty pull handshake as the master, and the receive side uses the same out/put push handshake, so ROM and FIFO sources and sinks plug in unchanged.

---
 rtl/spi_slave.sv | 147 ++++++++++++++
 tb/tb_spi_slave.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 target (MSB first). Oversamples the SPI pins with the system
// clock, pushes completed receive words out via put, and pulls transmit
// words from an upstream source via get/empty.
module spi_slave #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in,
    output logic         get,
    input  logic         empty,
    output logic [W-1:0] out,
    output logic         put,
    input  logic         spi_cs_n,
    input  logic         spi_clock,
    input  logic         spi_mosi,
    output logic         spi_miso
);

    localparam int CW = $clog2(W);

    // Synchroniser and edge-history flops
    logic cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d, cs_hist_q, cs_hist_d;
    logic sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_hist_q, sck_hist_d;
    logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;

    // Transfer state. The receive register only keeps W-1 bits: the final
    // bit of a word goes straight into out together with them.
    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-2:0]  rx_q, rx_d;
    logic [W-1:0]  tx_q, tx_d;
    logic [W-1:0]  out_q, out_d;
    logic          put_q, put_d;
    logic          get_q, get_d;
    logic          miso_q, miso_d;

    logic cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_fall  =  cs_hist_q  & ~cs_sync_q;
    assign cs_rise  = ~cs_hist_q  &  cs_sync_q;
    assign sck_rise = ~sck_hist_q &  sck_sync_q;
    assign sck_fall =  sck_hist_q & ~sck_sync_q;

    // Next-state logic: synchronisers, CS/SCK edge actions and MISO output
    always_comb begin
        cs_meta_d   = spi_cs_n;
        cs_sync_d   = cs_meta_q;
        cs_hist_d   = cs_sync_q;
        sck_meta_d  = spi_clock;
        sck_sync_d  = sck_meta_q;
        sck_hist_d  = sck_sync_q;
        mosi_meta_d = spi_mosi;
        mosi_sync_d = mosi_meta_q;

        active_d = active_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        out_d    = out_q;
        put_d    = 1'b0;
        get_d    = 1'b0;
        miso_d   = active_q ? tx_q[W-1] : 1'b1;

        if (cs_fall) begin
            // CS fall wins over any coincident SCK edge
            active_d = 1'b1;
            cnt_d    = '0;
            if (!empty) begin
                tx_d  = in;
                get_d = 1'b1;
            end else begin
                tx_d = '1;
            end
        end else if (cs_rise) begin
            // Partial receive word and any fetched transmit word are dropped
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (active_q && sck_rise) begin
            rx_d = {rx_q[W-3:0], mosi_sync_q};
            if (cnt_q == CW'(W - 1)) begin
                out_d = {rx_q, mosi_sync_q};
                put_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (active_q && sck_fall) begin
            if (cnt_q == '0) begin
                // Word boundary just crossed: fetch the next transmit word
                if (!empty) begin
                    tx_d  = in;
                    get_d = 1'b1;
                end else begin
                    tx_d = '1;
                end
            end else begin
                tx_d = {tx_q[W-2:0], 1'b1};
            end
        end
    end

    // State registers; synchronisers reset to idle pin levels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_hist_q   <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_hist_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            active_q    <= 1'b0;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '1;
            out_q       <= '0;
            put_q       <= 1'b0;
            get_q       <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            cs_meta_q   <= cs_meta_d;
            cs_sync_q   <= cs_sync_d;
            cs_hist_q   <= cs_hist_d;
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_hist_q  <= sck_hist_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            out_q       <= out_d;
            put_q       <= put_d;
            get_q       <= get_d;
            miso_q      <= miso_d;
        end
    end

    assign get      = get_q;
    assign put      = put_q;
    assign out      = out_q;
    assign spi_miso = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a transaction-level model predicts received words,
// MISO bit stream and number of source fetches per CS transfer.
module tb_spi_slave;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] src_word;
    logic         get;
    logic         empty;
    logic [W-1:0] out;
    logic         put;
    logic         cs_n, sck, mosi, miso;

    int total = 0;
    int bad   = 0;

    // Upstream FIFO source
    logic [W-1:0] src_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    // Receive-side expectations
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_out = '0;
    int get_cnt = 0;
    int cs_idle = 0;
    logic prev_get = 1'b0, prev_put = 1'b0;

    logic [W-1:0] mosi_w [0:3];
    logic [W-1:0] mw_got [0:3];

    always #5 clock = ~clock;

    assign empty    = (rd_ptr == wr_ptr);
    assign src_word = empty ? '0 : src_mem[rd_ptr % 256];

    spi_slave #(.W(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .in       (src_word),
        .get      (get),
        .empty    (empty),
        .out      (out),
        .put      (put),
        .spi_cs_n (cs_n),
        .spi_clock(sck),
        .spi_mosi (mosi),
        .spi_miso (miso)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push_src(input logic [W-1:0] v);
        src_mem[wr_ptr % 256] = v;
        wr_ptr++;
    endtask

    // Source consumes on the edge where get is high
    always @(posedge clock) begin
        if (get && !empty) rd_ptr <= rd_ptr + 1;
    end

    // Per-cycle output checker
    always @(negedge clock) begin
        if (!reset) begin
            check("rst_out", out, 0);
            check("rst_put", put, 0);
            check("rst_get", get, 0);
            check("rst_miso", miso, 1);
            exp_out  = '0;
            exp_q.delete();
            prev_get = 1'b0;
            prev_put = 1'b0;
        end else begin
            if (put) begin
                if (exp_q.size() == 0) check("put_unexpected", 1, 0);
                else exp_out = exp_q.pop_front();
                check("put_gap", prev_put, 0);
            end
            check("out_word", out, exp_out);
            if (get) begin
                get_cnt++;
                check("get_when_empty", empty, 0);
                check("get_gap", prev_get, 0);
            end
            if (cs_idle >= 5) check("miso_idle", miso, 1);
            prev_get = get;
            prev_put = put;
        end
        cs_idle = cs_n ? cs_idle + 1 : 0;
    end

    // One CS transfer of nbits bits with half-period h; checks MISO, gets, puts
    task automatic run_xfer(input int nbits, input int h);
        int avail, loads, exp_gets, g0;
        logic [W-1:0] words [0:7];
        avail    = wr_ptr - rd_ptr;
        loads    = 1 + nbits / W;
        exp_gets = (avail < loads) ? avail : loads;
        for (int j = 0; j < 8; j++)
            words[j] = (j < avail) ? src_mem[(rd_ptr + j) % 256] : '1;
        for (int j = 0; j < nbits / W; j++) exp_q.push_back(mosi_w[j]);
        for (int j = 0; j < 4; j++) mw_got[j] = '0;
        g0 = get_cnt;
        cs_n = 1'b0;
        repeat (3) tick();
        check("get_first", {31'b0, get}, {31'b0, avail > 0});
        repeat (2) tick();
        for (int i = 0; i < nbits; i++) begin
            mosi = mosi_w[i / W][W - 1 - (i % W)];
            repeat (h) tick();
            check("miso_bit", {31'b0, miso}, {31'b0, words[i / W][W - 1 - (i % W)]});
            mw_got[i / W] = {mw_got[i / W][W-2:0], miso};
            sck = 1'b1;
            repeat (h) tick();
            sck = 1'b0;
        end
        repeat (h) tick();
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) tick();
        check("get_count", get_cnt - g0, exp_gets);
        check("put_missing", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        cs_n  = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;

        // Reset held while pins toggle
        for (int i = 0; i < 20; i++) begin
            tick();
            cs_n = 1'($urandom);
            sck  = 1'($urandom);
            mosi = 1'($urandom);
        end
        cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        repeat (4) tick();

        // Single byte
        push_src(8'hA5);
        mosi_w[0] = 8'h3C;
        run_xfer(8, 5);
        check("single_miso", mw_got[0], 8'hA5);
        check("single_out", out, 8'h3C);

        // Empty source
        mosi_w[0] = 8'h5A;
        run_xfer(8, 5);
        check("empty_miso", mw_got[0], 8'hFF);
        check("empty_out", out, 8'h5A);

        // Back-to-back words under one CS
        push_src(8'h11);
        push_src(8'h22);
        mosi_w[0] = 8'h48;
        mosi_w[1] = 8'h69;
        run_xfer(16, 5);
        check("b2b_miso0", mw_got[0], 8'h11);
        check("b2b_miso1", mw_got[1], 8'h22);
        check("b2b_out", out, 8'h69);

        // Abort after 5 bits, then a full word
        mosi_w[0] = 8'hFF;
        run_xfer(5, 5);
        check("abort_out_held", out, 8'h69);
        mosi_w[0] = 8'hC3;
        run_xfer(8, 6);
        check("abort_out", out, 8'hC3);

        // Reset in the middle of a transfer
        cs_n = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            repeat (5) tick();
            sck = 1'b1;
            repeat (5) tick();
            sck = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("midrst_out", out, 0);
        check("midrst_put", put, 0);
        check("midrst_get", get, 0);
        check("midrst_miso", miso, 1);
        cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        repeat (4) tick();
        mosi_w[0] = 8'h96;
        run_xfer(8, 5);
        check("midrst_after", out, 8'h96);

        // Randomised transfers
        for (int t = 0; t < 20; t++) begin
            int nw, nb, h, np;
            np = $urandom_range(0, 4);
            for (int k = 0; k < np; k++) push_src(W'($urandom));
            nw = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) mosi_w[k] = W'($urandom);
            nb = nw * W;
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, nw * W - 1);
            h = $urandom_range(5, 8);
            run_xfer(nb, h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
